// File: rtl/mem_if_pkg.sv
// Shared types and defaults for the CPU memory-interface controller.
package mem_if_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GPIO_ACC = 2'd1,
        RAM_ACC  = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Wide all-ones so any address width can slice its own GPIO address from it.
    localparam logic [31:0] DEF_GPIO_ADDR = 32'hFFFF_FFFF;
    localparam int          DEF_RAM_WAIT  = 1;

endpackage

// File: rtl/mem_if_ctrl.sv
// Turns single CPU load/store requests into one GPIO register access or one
// wait-stated synchronous RAM access, finishing each with a one-cycle ready pulse.
module mem_if_ctrl
    import mem_if_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] GPIO_ADDR = DEF_GPIO_ADDR[ADDR_W-1:0],
    parameter int                RAM_WAIT  = DEF_RAM_WAIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] gpio_write,
    output logic              gpio_wr,
    input  logic [DATA_W-1:0] gpio_read,
    output logic [1:0]        state_dbg
);

    localparam int CNT_W = (RAM_WAIT < 1) ? 1 : $clog2(RAM_WAIT + 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q;
    logic              accept;
    logic              ram_last;

    assign accept   = (state == IDLE) && cpu_req;
    assign ram_last = (state == RAM_ACC) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Strobes depend on the state register and latched we_q only.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        gpio_wr   = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        cpu_ready = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    if (cpu_addr == GPIO_ADDR) begin
                        state_d = GPIO_ACC;
                    end else begin
                        state_d = RAM_ACC;
                        cnt_d   = CNT_W'(RAM_WAIT);
                    end
                end
            end
            GPIO_ACC: begin
                gpio_wr = we_q;
                state_d = DONE;
            end
            RAM_ACC: begin
                ram_en = 1'b1;
                ram_we = we_q;
                if (cnt == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                cpu_ready = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            if (accept) begin
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
                we_q    <= cpu_we;
            end
            // Loads capture on the edge that leaves the access state; stores keep cpu_rdata.
            if ((state == GPIO_ACC) && !we_q) begin
                cpu_rdata <= gpio_read;
            end else if (ram_last && !we_q) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

    assign ram_addr   = addr_q;
    assign ram_wdata  = wdata_q;
    assign gpio_write = wdata_q;
    assign state_dbg  = state;

endmodule
